// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared between the ALU and its command sequencer.
// Contents:
//   - the 3-bit opcode encodings ADD..EQU
//   - the sequencer state encoding IDLE/EXEC/RESP
//   - flag bit positions inside the 4-bit {neg, zero, overflow, carry} word
//   - is_cmp(), which marks the compare opcodes that do not write the accumulator
package alu_pkg;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] NOT  = 3'b010;
  localparam logic [2:0] AND  = 3'b011;
  localparam logic [2:0] OR   = 3'b100;
  localparam logic [2:0] XOR  = 3'b101;
  localparam logic [2:0] COMP = 3'b110;
  localparam logic [2:0] EQU  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;

  // Compare opcodes run exactly once and leave the accumulator untouched.
  function automatic logic is_cmp(input logic [2:0] op);
    return (op == COMP) || (op == EQU);
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational golden ALU. It produces the result only, and
// the sequencer instantiates it only when ALU_CHECK_EN is defined.
// Ports:
//   a, b : operands (DATAWIDTH)
//   op   : opcode (3 bits, encodings from alu_pkg)
//   r    : expected result (DATAWIDTH)
// Compare semantics: COMP gives 1 when a > b (unsigned). EQU gives 1 when a == b.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [2:0]           op,
  output logic [DATAWIDTH-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      ADD:     r = a + b;
      SUB:     r = a - b;
      NOT:     r = ~a;
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      COMP:    r = (a > b) ? DATAWIDTH'(1) : '0;
      EQU:     r = (a == b) ? DATAWIDTH'(1) : '0;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: the initiator side of the ALU operand/opcode interface.
// It accepts a command on the cmd_* valid/ready stream. A load writes operand
// B into the accumulator. Any other command drives the ALU with
// {acc, cmd_b, cmd_op} and repeats the operation cmd_rep+1 times, feeding
// the result back as operand A. The final result and flags are returned on
// the rsp_* valid/ready stream.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_load, cmd_b, cmd_rep command fields
//   alu_a, alu_b, alu_op             registered drive to the combinational ALU
//   alu_r, alu_carry, alu_overflow   ALU outputs, sampled every EXEC cycle
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_flags              result and {neg, zero, overflow, carry}
// Optional build macro ALU_CHECK_EN:
//   adds the chk_err output (sticky) and the chk_cnt output (16-bit,
//   saturating). These compare alu_r against an internal reference ALU on
//   every EXEC cycle.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int REPW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ALU_CHECK_EN
  output logic                 chk_err,
  output logic [15:0]          chk_cnt,
`endif
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic                 cmd_load,
  input  logic [DATAWIDTH-1:0] cmd_b,
  input  logic [REPW-1:0]      cmd_rep,
  output logic [DATAWIDTH-1:0] alu_a,
  output logic [DATAWIDTH-1:0] alu_b,
  output logic [2:0]           alu_op,
  input  logic [DATAWIDTH-1:0] alu_r,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_data,
  output logic [3:0]           rsp_flags
);

  state_t               state_reg, state_next;
  logic [DATAWIDTH-1:0] acc_reg, acc_next;
  logic [DATAWIDTH-1:0] alu_a_reg, alu_a_next;
  logic [DATAWIDTH-1:0] alu_b_reg, alu_b_next;
  logic [2:0]           alu_op_reg, alu_op_next;
  logic [REPW-1:0]      rep_reg, rep_next;
  logic [REPW-1:0]      cnt_reg, cnt_next;
  logic                 c_sticky_reg, c_sticky_next;
  logic                 v_sticky_reg, v_sticky_next;
  logic [DATAWIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic [3:0]           rsp_flags_reg, rsp_flags_next;
  logic                 c_now, v_now;

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_flags = rsp_flags_reg;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    alu_op_next    = alu_op_reg;
    rep_next       = rep_reg;
    cnt_next       = cnt_reg;
    c_sticky_next  = c_sticky_reg;
    v_sticky_next  = v_sticky_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_flags_next = rsp_flags_reg;
    c_now          = c_sticky_reg | alu_carry;
    v_now          = v_sticky_reg | alu_overflow;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;

    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_load) begin
            acc_next              = cmd_b;
            rsp_data_next         = cmd_b;
            rsp_flags_next        = '0;
            rsp_flags_next[FLG_N] = cmd_b[DATAWIDTH-1];
            rsp_flags_next[FLG_Z] = (cmd_b == '0);
            state_next            = RESP;
          end else begin
            alu_a_next    = acc_reg;
            alu_b_next    = cmd_b;
            alu_op_next   = cmd_op;
            // Compares ignore the repeat count, so they finish after one pass.
            rep_next      = is_cmp(cmd_op) ? '0 : cmd_rep;
            cnt_next      = '0;
            c_sticky_next = 1'b0;
            v_sticky_next = 1'b0;
            state_next    = EXEC;
          end
        end
      end

      EXEC: begin
        c_sticky_next = c_now;
        v_sticky_next = v_now;
        if (!is_cmp(alu_op_reg)) begin
          acc_next   = alu_r;
          alu_a_next = alu_r;
        end
        // Compare before incrementing. With rep = all-ones the counter stops
        // at the top value and never wraps into a further pass.
        if (cnt_reg == rep_reg) begin
          rsp_data_next         = alu_r;
          rsp_flags_next[FLG_N] = alu_r[DATAWIDTH-1];
          rsp_flags_next[FLG_Z] = (alu_r == '0);
          rsp_flags_next[FLG_V] = v_now;
          rsp_flags_next[FLG_C] = c_now;
          state_next            = RESP;
        end else begin
          cnt_next = cnt_reg + REPW'(1);
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      rep_reg       <= '0;
      cnt_reg       <= '0;
      c_sticky_reg  <= 1'b0;
      v_sticky_reg  <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_flags_reg <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      alu_op_reg    <= alu_op_next;
      rep_reg       <= rep_next;
      cnt_reg       <= cnt_next;
      c_sticky_reg  <= c_sticky_next;
      v_sticky_reg  <= v_sticky_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_flags_reg <= rsp_flags_next;
    end
  end

`ifdef ALU_CHECK_EN
  logic [DATAWIDTH-1:0] ref_r;
  logic                 chk_err_reg;
  logic [15:0]          chk_cnt_reg;
  logic                 mismatch;

  alu_ref_model #(
    .DATAWIDTH(DATAWIDTH)
  ) u_ref (
    .a  (alu_a_reg),
    .b  (alu_b_reg),
    .op (alu_op_reg),
    .r  (ref_r)
  );

  assign mismatch = (state_reg == EXEC) && (ref_r != alu_r);
  assign chk_err  = chk_err_reg;
  assign chk_cnt  = chk_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_reg <= 1'b0;
      chk_cnt_reg <= '0;
    end else if (mismatch) begin
      chk_err_reg <= 1'b1;
      if (chk_cnt_reg != 16'hFFFF) begin
        chk_cnt_reg <= chk_cnt_reg + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer. A behavioural ALU answers the DUT's
// operand outputs. Every expected result, flag word and latency below is
// worked out by hand from the command sequence. Latency is numbered so that
// 1 means the response handshakes at the first edge after the accept edge.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [2:0] cmd_op;
  logic [7:0] cmd_b;
  logic [3:0] cmd_rep;
  logic [7:0] alu_a, alu_b, alu_r;
  logic [2:0] alu_op;
  logic       alu_carry, alu_overflow;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
`ifdef ALU_CHECK_EN
  logic        chk_err;
  logic [15:0] chk_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATAWIDTH(8), .REPW(4)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ALU_CHECK_EN
    .chk_err      (chk_err),
    .chk_cnt      (chk_cnt),
`endif
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_load     (cmd_load),
    .cmd_b        (cmd_b),
    .cmd_rep      (cmd_rep),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_r        (alu_r),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_flags    (rsp_flags)
  );

  // Behavioural ALU. SUB reports a borrow as carry. COMP means a > b (unsigned).
  logic [8:0] wide;
  always_comb begin
    wide = '0; alu_r = '0; alu_carry = 1'b0; alu_overflow = 1'b0;
    case (alu_op)
      3'b000: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_r = wide[7:0]; alu_carry = wide[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
      end
      3'b001: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_r = wide[7:0]; alu_carry = wide[8];
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_r[7] != alu_a[7]);
      end
      3'b010: alu_r = ~alu_a;
      3'b011: alu_r = alu_a & alu_b;
      3'b100: alu_r = alu_a | alu_b;
      3'b101: alu_r = alu_a ^ alu_b;
      3'b110: alu_r = (alu_a > alu_b) ? 8'd1 : 8'd0;
      default: alu_r = (alu_a == alu_b) ? 8'd1 : 8'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command, measures the response latency, checks data and flags,
  // and optionally holds rsp_ready low for 'stall' cycles while injecting
  // stray commands. It returns right after the handshake edge.
  task automatic run_cmd(input string tag, input logic load, input logic [2:0] op,
                         input logic [7:0] b, input logic [3:0] rep,
                         input logic [7:0] exp_data, input logic [3:0] exp_flags,
                         input int exp_lat, input int stall);
    int j;
    @(negedge clk);
    check({tag, "_ready_idle"}, cmd_ready, 1);
    rsp_ready = (stall == 0);
    cmd_valid = 1'b1; cmd_load = load; cmd_op = op; cmd_b = b; cmd_rep = rep;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_b = 8'hA5; cmd_op = 3'b000; cmd_rep = 4'hF; cmd_load = 1'b0;
    @(negedge clk);
    j = 0;
    while (!rsp_valid && j < 40) begin
      check({tag, "_busy_ready"}, cmd_ready, 0);
      @(negedge clk);
      j++;
    end
    check({tag, "_latency"}, j + 1, exp_lat);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_flags"}, rsp_flags, exp_flags);
    check({tag, "_resp_ready"}, cmd_ready, 0);
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        cmd_valid = s[0]; cmd_load = 1'b1; cmd_b = 8'h55;
        @(negedge clk);
        check({tag, "_stall_valid"}, rsp_valid, 1);
        check({tag, "_stall_data"}, rsp_data, exp_data);
        check({tag, "_stall_flags"}, rsp_flags, exp_flags);
        check({tag, "_stall_ready"}, cmd_ready, 0);
      end
      cmd_valid = 1'b0; cmd_load = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    $display("%s: data=0x%02h flags=%04b latency=%0d", tag, rsp_data, rsp_flags, j + 1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'b000;
    cmd_b = 8'h00; cmd_rep = 4'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    $display("reset: cmd_ready=%0b rsp_valid=%0b", cmd_ready, rsp_valid);

    //       tag        load op      b      rep   data   flags    lat stall
    run_cmd("load7f",   1, 3'b000, 8'h7F, 4'd0, 8'h7F, 4'b0000, 1,  0);
    run_cmd("add_ovf",  0, 3'b000, 8'h01, 4'd0, 8'h80, 4'b1010, 2,  0);
    run_cmd("load00",   1, 3'b000, 8'h00, 4'd0, 8'h00, 4'b0100, 1,  0);
    run_cmd("add_rep3", 0, 3'b000, 8'h10, 4'd3, 8'h40, 4'b0000, 5,  0);
    run_cmd("not_rep1", 0, 3'b010, 8'h00, 4'd1, 8'h40, 4'b0000, 3,  0);
    run_cmd("load05",   1, 3'b000, 8'h05, 4'd0, 8'h05, 4'b0000, 1,  0);
    run_cmd("sub_zero", 0, 3'b001, 8'h05, 4'd0, 8'h00, 4'b0100, 2,  0);
    run_cmd("equ_rep7", 0, 3'b111, 8'h00, 4'd7, 8'h01, 4'b0000, 2,  0);
    run_cmd("add_acc0", 0, 3'b000, 8'h01, 4'd0, 8'h01, 4'b0000, 2,  0);
    run_cmd("sub_brw",  0, 3'b001, 8'h03, 4'd0, 8'hFE, 4'b1001, 2,  0);
    run_cmd("xor_rep1", 0, 3'b101, 8'h0F, 4'd1, 8'hFE, 4'b1000, 3,  0);
    run_cmd("add_stall",0, 3'b000, 8'h02, 4'd0, 8'h00, 4'b0101, 2,  10);
    run_cmd("add_post", 0, 3'b000, 8'h07, 4'd0, 8'h07, 4'b0000, 2,  0);
    run_cmd("loadff",   1, 3'b000, 8'hFF, 4'd0, 8'hFF, 4'b1000, 1,  0);
    run_cmd("add_rep15",0, 3'b000, 8'h01, 4'd15,8'h0F, 4'b0001, 17, 0);
    run_cmd("comp_gt",  0, 3'b110, 8'h03, 4'd2, 8'h01, 4'b0000, 2,  0);
    run_cmd("and_f0",   0, 3'b011, 8'hF0, 4'd0, 8'h00, 4'b0100, 2,  0);
    run_cmd("or_3c",    0, 3'b100, 8'h3C, 4'd0, 8'h3C, 4'b0000, 2,  0);

    // Reset in the middle of a rep=5 ADD discards the command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'b000; cmd_b = 8'h01; cmd_rep = 4'd5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_rsp_flags", rsp_flags, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", rsp_valid, 0);
    end
    $display("mid_exec_reset: rsp_valid=%0b cmd_ready=%0b", rsp_valid, cmd_ready);
    run_cmd("add_after_rst", 0, 3'b000, 8'h03, 4'd0, 8'h03, 4'b0000, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
